// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states, latched op flags.
package muldiv_pkg;

    // EX op encoding, sampled with start
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Per-op flags captured at accept and consumed in FIXUP
    typedef struct packed {
        logic is_div;   // divide (1) or multiply (0)
        logic neg_a;    // rs operand was negative (signed op)
        logic neg_b;    // rt operand was negative (signed op)
        logic div0;     // divide with zero divisor
    } op_flags_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide loop, purely combinational.
//  Multiply: acc += a when b[0]; a <<= 1; b >>= 1 (a holds the shifted multiplicand).
//  Divide:   restoring step; acc[W-1:0] is the partial remainder, a[W-1:0] the dividend
//            shifting out at the top while quotient bits shift in at the bottom, b the divisor.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [2*WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [2*WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]     b_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Single shift-add or trial-subtract iteration
    always_comb begin
        rem_sh = {acc_i[WIDTH-1:0], a_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_i};
        acc_o  = acc_i;
        a_o    = a_i;
        b_o    = b_i;
        if (is_div) begin
            // diff[WIDTH] is the borrow: clear means the divisor fits
            if (!diff[WIDTH]) begin
                acc_o = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                a_o   = {{WIDTH{1'b0}}, a_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {{WIDTH{1'b0}}, rem_sh[WIDTH-1:0]};
                a_o   = {{WIDTH{1'b0}}, a_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (b_i[0]) begin
                acc_o = acc_i + a_i;
            end
            a_o = {a_i[2*WIDTH-2:0], 1'b0};
            b_o = {1'b0, b_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Magnitudes are iterated one bit per cycle, then FIXUP restores signs and writes HI/LO.
// Optional build macro: MULDIV_EARLY_TERM_EN -- multiplies leave RUN as soon as the
// remaining multiplier bits are zero.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  rs_data,
    input  logic [WIDTH-1:0]  rt_data,
    input  logic              rd_hilo,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    op_flags_t            flags_q, flags_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [2*WIDTH-1:0]   step_acc;
    logic [2*WIDTH-1:0]   step_a;
    logic [WIDTH-1:0]     step_b;

    // Accept-time operand conditioning
    logic                 op_signed;
    logic                 in_neg_a;
    logic                 in_neg_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    // Fixup results
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (flags_q.is_div),
        .acc_i  (acc_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .acc_o  (step_acc),
        .a_o    (step_a),
        .b_o    (step_b)
    );

    // Operand magnitudes and sign flags for a newly issued op
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        in_neg_a  = op_signed && rs_data[WIDTH-1];
        in_neg_b  = op_signed && rt_data[WIDTH-1];
        mag_a     = in_neg_a ? (~rs_data + WIDTH'(1)) : rs_data;
        mag_b     = in_neg_b ? (~rt_data + WIDTH'(1)) : rt_data;
    end

    // Sign restoration: quotient/product by sign mismatch, remainder follows the dividend
    always_comb begin
        prod_fix = (flags_q.neg_a ^ flags_q.neg_b) ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        quot_fix = (flags_q.neg_a ^ flags_q.neg_b) ? (~a_q[WIDTH-1:0] + WIDTH'(1))
                                                   : a_q[WIDTH-1:0];
        rem_fix  = flags_q.neg_a ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    end

    // Next-state, counter and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        flags_d = flags_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d        = ST_RUN;
                    cnt_d          = '0;
                    acc_d          = '0;
                    a_d            = {{WIDTH{1'b0}}, mag_a};
                    b_d            = mag_b;
                    flags_d.is_div = op[1];
                    flags_d.neg_a  = in_neg_a;
                    flags_d.neg_b  = in_neg_b;
                    flags_d.div0   = op[1] && (rt_data == '0);
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                a_d   = step_a;
                b_d   = step_b;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_FIXUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef MULDIV_EARLY_TERM_EN
                    // Product is already complete once no multiplier bits remain
                    if (!flags_q.is_div && (step_b == '0)) begin
                        state_d = ST_FIXUP;
                    end
`endif
                end
            end
            ST_FIXUP: begin
                state_d = ST_DONE;
                if (flags_q.is_div) begin
                    lo_d = flags_q.div0 ? '1 : quot_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, HI/LO and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = (start | rd_hilo) & busy_q & ~done_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, signed/unsigned results, divide-by-zero,
// overflow, stall/back-to-back accept, mid-op reset, optional early termination.
module tb_muldiv_ctrl;

    localparam int unsigned WIDTH = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  rs_data;
    logic [WIDTH-1:0]  rt_data;
    logic              rd_hilo;
    logic              busy;
    logic              stall;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    int tests;
    int fails;
    int lat;
    int exp_lat_short;

    muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .rd_hilo (rd_hilo),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an op in the current cycle (cycle 0), return cycle count until done
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = '0;
        rt_data = '0;
        rd_hilo = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("reset_busy",  64'(busy),  64'd0);
        check("reset_done",  64'(done),  64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_hilo",  {hi, lo},   64'd0);
        tick();

        // 1. MULTU all-ones squared, fixed latency
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("multu_lat",  64'(lat),  64'd34);
        check("multu_hilo", {hi, lo},  64'hFFFF_FFFE_0000_0001);
        check("multu_done_stall", 64'(stall), 64'd0);
        tick();
        check("done_pulse_clears", 64'(done), 64'd0);
        check("idle_after_done",   64'(busy), 64'd0);
        tick();
        tick();
        check("hilo_hold_idle", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // 2. Signed multiply and divide
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat);
        check("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_neg_lat",  64'(lat), 64'd34);
        check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat);
        check("div_negdivisor_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        // 3. Divide by zero and signed overflow
        run_op(2'b11, 32'd100, 32'd0, lat);
        check("divu0_lat",  64'(lat), 64'd34);
        check("divu0_hilo", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, lat);
        check("div0_neg_hilo", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        tick();
        tick();

        // 4. MFHI/MFLO and second start collide with an op in flight
        start   = 1'b1;
        op      = 2'b11;
        rs_data = 32'd100;
        rt_data = 32'd7;
        for (int c = 1; c <= 68; c++) begin
            tick();
            if (c == 1) begin
                start = 1'b0;
            end
            if (c == 5) begin
                start   = 1'b1;
                op      = 2'b11;
                rs_data = 32'd1000;
                rt_data = 32'd3;
                rd_hilo = 1'b1;
            end
            if (c == 35) begin
                start   = 1'b0;
                rd_hilo = 1'b0;
            end
            #1;
            if (c == 4) check("col_nostall_c4", 64'(stall), 64'd0);
            if (c == 5 || c == 20 || c == 33) begin
                check($sformatf("col_stall_c%0d", c), 64'(stall), 64'd1);
                check($sformatf("col_notdone_c%0d", c), 64'(done), 64'd0);
            end
            if (c == 34) begin
                check("col_done_c34",  64'(done),  64'd1);
                check("col_stall_c34", 64'(stall), 64'd0);
                check("col_first_c34", {hi, lo},   64'h0000_0002_0000_000E);
            end
            if (c == 35) begin
                check("col_second_busy",  64'(busy), 64'd1);
                check("col_second_nodone", 64'(done), 64'd0);
            end
            if (c == 67) check("col_hold_c67", {hi, lo}, 64'h0000_0002_0000_000E);
            if (c == 68) begin
                check("col_done_c68",   64'(done), 64'd1);
                check("col_second_c68", {hi, lo},  64'h0000_0001_0000_014D);
            end
        end
        tick();
        tick();

        // 5. Reset in the middle of a DIVU
        start   = 1'b1;
        op      = 2'b11;
        rs_data = 32'd100;
        rt_data = 32'd7;
        for (int c = 1; c <= 11; c++) begin
            tick();
            start = 1'b0;
            if (c == 10) rst = 1'b1;
            if (c == 11) rst = 1'b0;
        end
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hilo", {hi, lo},  64'd0);
        tick();
        run_op(2'b11, 32'd100, 32'd7, lat);
        check("post_rst_lat",  64'(lat), 64'd34);
        check("post_rst_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

        // 6. Short multiplier: early exit when enabled
`ifdef MULDIV_EARLY_TERM_EN
        exp_lat_short = 3;
`else
        exp_lat_short = 34;
`endif
        run_op(2'b01, 32'd5, 32'd1, lat);
        check("multu_short_lat", 64'(lat), 64'(exp_lat_short));
        check("multu_short_hilo", {hi, lo}, 64'h0000_0000_0000_0005);
        run_op(2'b00, 32'h1234_5678, 32'd0, lat);
        check("mult_zero_lat",  64'(lat), 64'(exp_lat_short));
        check("mult_zero_hilo", {hi, lo}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
